// File: rtl/ram_burst_ctrl_if.sv
// ram_burst_ctrl_if: bundles the stream and RAM-side signals of ram_burst_ctrl.
//   Producer side : in_valid, in_data, in_last -> controller ; in_ready <- controller
//   Consumer side : out_valid, out_data, out_last <- controller ; out_ready -> controller
//   RAM side      : ram_we, ram_addr_wr, ram_data_wr, ram_addr_rd <- controller ;
//                   ram_data_rd -> controller (asynchronous RAM read data)
//   Status        : burst_len <- controller
// Modports: slave = the burst controller, master = its environment
// (producer, consumer and RAM together).
interface ram_burst_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 2
);
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready;
  logic                 out_last;
  logic                 ram_we;
  logic [DEPTH_LOG-1:0] ram_addr_wr;
  logic [WIDTH-1:0]     ram_data_wr;
  logic [DEPTH_LOG-1:0] ram_addr_rd;
  logic [WIDTH-1:0]     ram_data_rd;
  logic [DEPTH_LOG:0]   burst_len;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, ram_data_rd,
    output in_ready, out_valid, out_data, out_last,
           ram_we, ram_addr_wr, ram_data_wr, ram_addr_rd, burst_len
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, ram_data_rd,
    input  in_ready, out_valid, out_data, out_last,
           ram_we, ram_addr_wr, ram_data_wr, ram_addr_rd, burst_len
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: turns a small asynchronous-read RAM into a fill-then-drain
// burst buffer. Input words are written until the RAM is full or in_last is
// seen; the captured burst is then streamed out, one word per cycle, under
// out_valid/out_ready flow control. FILL and DRAIN never overlap.
//
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - ram_burst_ctrl_if.slave: producer stream (in_*), consumer stream
//          (out_*), RAM write/read ports (ram_*) and burst_len status
//
// Optional feature: define BURST_REVERSE_EN to drain the burst in reverse
// (LIFO) order. Default build drains in FIFO order.
module ram_burst_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input logic              clk,
  input logic              rst,
  ram_burst_ctrl_if.slave  bus
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [DEPTH_LOG:0] ONE      = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG:0] LAST_IDX = (DEPTH_LOG+1)'(DEPTH-1);

  state_t             state, state_nxt;
  logic [DEPTH_LOG:0] wr_ptr, wr_ptr_nxt;
  logic [DEPTH_LOG:0] rd_ptr, rd_ptr_nxt;
  logic [DEPTH_LOG:0] len, len_nxt;
  logic               accept;
  logic               last_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      len    <= len_nxt;
    end
  end

  // Handshake outputs are gated with ~rst so nothing is accepted or offered
  // while reset is asserted, even before the first reset edge.
  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    len_nxt       = len;
    accept        = 1'b0;
    last_rd       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.ram_we    = 1'b0;
    case (state)
      FILL: begin
        bus.in_ready = ~rst;
        accept       = bus.in_valid & ~rst;
        bus.ram_we   = accept;
        if (accept) begin
          wr_ptr_nxt = wr_ptr + ONE;
          if (bus.in_last || (wr_ptr == LAST_IDX)) begin
            len_nxt    = wr_ptr + ONE;
`ifdef BURST_REVERSE_EN
            // Start from the newest word: len-1 equals the current wr_ptr.
            rd_ptr_nxt = wr_ptr;
`else
            rd_ptr_nxt = '0;
`endif
            state_nxt  = DRAIN;
          end
        end
      end
      DRAIN: begin
`ifdef BURST_REVERSE_EN
        last_rd = (rd_ptr == '0);
`else
        last_rd = (rd_ptr == (len - ONE));
`endif
        bus.out_valid = ~rst;
        bus.out_last  = last_rd & ~rst;
        if (bus.out_ready && !rst) begin
`ifdef BURST_REVERSE_EN
          rd_ptr_nxt = rd_ptr - ONE;
`else
          rd_ptr_nxt = rd_ptr + ONE;
`endif
          if (last_rd) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            state_nxt  = FILL;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // RAM read is asynchronous, so the read data feeds out_data directly.
  assign bus.ram_addr_wr = wr_ptr[DEPTH_LOG-1:0];
  assign bus.ram_data_wr = bus.in_data;
  assign bus.ram_addr_rd = rd_ptr[DEPTH_LOG-1:0];
  assign bus.out_data    = bus.ram_data_rd;
  assign bus.burst_len   = len;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with a behavioural 4x8 RAM attached.
module tb_ram_burst_ctrl;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int DEPTH_LOG = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_burst_ctrl_if #(.WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) bus ();

  ram_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural RAM: synchronous write, asynchronous read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr_wr] <= bus.ram_data_wr;
  assign bus.ram_data_rd = mem[bus.ram_addr_rd];

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a burst is a list of accepted words; once closed it
  // becomes a queue of words still to be emitted.
  logic [WIDTH-1:0] m_buf[$];
  logic [WIDTH-1:0] m_out[$];
  int m_len   = 0;
  bit m_drain = 1'b0;

  logic             cur_v, cur_l, cur_or, cur_r;
  logic [WIDTH-1:0] cur_d;

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l,
                       input logic ordy, input logic r);
    cur_v = v; cur_d = d; cur_l = l; cur_or = ordy; cur_r = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    rst           = r;
  endtask

  task automatic model_check();
    if (cur_r) begin
      chk("rst_in_ready",  bus.in_ready,  0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last",  bus.out_last,  0);
      chk("rst_ram_we",    bus.ram_we,    0);
      chk("rst_burst_len", bus.burst_len, m_len);
    end else if (!m_drain) begin
      chk("fill_in_ready",  bus.in_ready,  1);
      chk("fill_out_valid", bus.out_valid, 0);
      chk("fill_ram_we",    bus.ram_we,    cur_v);
      if (cur_v) begin
        chk("fill_addr_wr", bus.ram_addr_wr, m_buf.size());
        chk("fill_data_wr", bus.ram_data_wr, cur_d);
      end
      chk("fill_addr_rd",   bus.ram_addr_rd, 0);
      chk("fill_burst_len", bus.burst_len,   m_len);
    end else begin
      chk("drain_in_ready",  bus.in_ready,  0);
      chk("drain_ram_we",    bus.ram_we,    0);
      chk("drain_out_valid", bus.out_valid, 1);
      chk("drain_out_data",  bus.out_data,  m_out[0]);
      chk("drain_out_last",  bus.out_last,  (m_out.size() == 1));
      chk("drain_burst_len", bus.burst_len, m_len);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_r) begin
      m_buf.delete(); m_out.delete(); m_len = 0; m_drain = 1'b0;
    end else if (!m_drain) begin
      if (cur_v) begin
        m_buf.push_back(cur_d);
        if (cur_l || m_buf.size() == DEPTH) begin
          m_len = m_buf.size();
          m_out.delete();
          for (int i = 0; i < m_buf.size(); i++) begin
`ifdef BURST_REVERSE_EN
            m_out.push_front(m_buf[i]);
`else
            m_out.push_back(m_buf[i]);
`endif
          end
          m_drain = 1'b1;
        end
      end
    end else if (cur_or) begin
      void'(m_out.pop_front());
      if (m_out.size() == 0) begin
        m_drain = 1'b0;
        m_buf.delete();
      end
    end
    #1;
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic l,
                      input logic ordy, input logic r);
    drive(v, d, l, ordy, r);
    #3;
    model_check();
    advance();
  endtask

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             l;
    logic             ordy;
    logic             e_ir;
    logic             e_ov;
    logic [WIDTH-1:0] e_od;
    logic             e_ol;
    logic             e_we;
    logic [1:0]       e_wa;
    logic [2:0]       e_bl;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Full burst: 4 words back-to-back, drained with out_ready held high.
    //          v     d      l     ordy  ir    ov    od     ol    we    wa     bl
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 3'd0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 3'd0};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 3'd0};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 3'd0};
`ifdef BURST_REVERSE_EN
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 2'd0, 3'd4};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 2'd0, 3'd4};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 2'd0, 3'd4};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 2'd0, 3'd4};
`else
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 3'd4};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 2'd0, 3'd4};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 2'd0, 3'd4};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 2'd0, 3'd4};
`endif
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 3'd4};

    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ordy, 1'b0);
      #3;
      chk($sformatf("tbl%0d_in_ready", i),  bus.in_ready,  vecs[i].e_ir);
      chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        chk($sformatf("tbl%0d_out_data", i), bus.out_data, vecs[i].e_od);
        chk($sformatf("tbl%0d_out_last", i), bus.out_last, vecs[i].e_ol);
      end
      chk($sformatf("tbl%0d_ram_we", i), bus.ram_we, vecs[i].e_we);
      if (vecs[i].e_we) chk($sformatf("tbl%0d_addr_wr", i), bus.ram_addr_wr, vecs[i].e_wa);
      chk($sformatf("tbl%0d_burst_len", i), bus.burst_len, vecs[i].e_bl);
      model_check();
      advance();
    end

    // Short burst of two words, then next burst must restart at address 0.
    step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Backpressure with a producer pushing during DRAIN.
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Reset after two of four outputs, then a single-word burst.
    step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Single-word burst 0xFF.
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Randomized traffic including occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), WIDTH'($urandom), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
